// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester.
// Data wins by default; fetch is forced through after MAX_STARVE data grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              i_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              err_sticky,
    output logic [2:0]        dbg_state
);
    // Handshake: a requester raises req with stable fields and holds them until the
    // cycle its done is 1; memory completes a command by raising mem_ack while mem_req=1.
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int BW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              grant_i, grant_d, timeout, in_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            busy_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign in_busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || starve_q < SW'(MAX_STARVE))) begin
                    state_d = BUSY_D;
                    grant_d = 1'b1;
                end else if (i_req) begin
                    state_d = BUSY_I;
                    grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack arriving on the timeout edge still completes normally.
                if (mem_ack) begin
                    state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
                end else if (busy_q == BW'(TIMEOUT - 1)) begin
                    state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
                    timeout = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d     = starve_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = (state_d == RESP_I);
        d_done_d     = (state_d == RESP_D);
        err_d        = timeout;
        err_sticky_d = err_sticky_q | timeout;
        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            busy_d      = '0;
            if (!i_req)
                starve_d = '0;
            else if (starve_q != SW'(MAX_STARVE))
                starve_d = starve_q + SW'(1);
        end
        if (grant_i) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            busy_d      = '0;
            starve_d    = '0;
        end
        if (in_busy) begin
            if (!mem_ack)
                busy_d = busy_q + BW'(1);
            if (state_d != state_q)
                mem_req_d = 1'b0;
            if (mem_ack && state_q == BUSY_I)
                i_rdata_d = mem_rdata[31:0];
            if (mem_ack && state_q == BUSY_D)
                d_rdata_d = mem_rdata;
        end
    end

    assign i_stall    = i_req & ~i_done_q;
    assign d_stall    = d_req & ~d_done_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random requesters and memory checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MAX_STARVE = 3;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          i_done, d_done, i_stall, d_stall, mem_req, mem_we, err, err_sticky;
    logic [31:0]   i_rdata;
    logic [DW-1:0] d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .i_stall(i_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .err_sticky(err_sticky), .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endfunction

    // Transaction-level reference: one outstanding command, a wait counter and a
    // streak of data grants that overtook a waiting fetch.
    logic          m_busy = 0, m_resp = 0, m_own_d = 0;
    int            m_wait = 0, m_streak = 0;
    logic          m_mem_req = 0, m_mem_we = 0;
    logic [AW-1:0] m_mem_addr = '0;
    logic [DW-1:0] m_mem_wdata = '0, m_d_rdata = '0;
    logic [31:0]   m_i_rdata = '0;
    logic          m_i_done = 0, m_d_done = 0, m_err = 0, m_err_sticky = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_resp = 0; m_own_d = 0; m_wait = 0; m_streak = 0;
            m_mem_req = 0; m_mem_we = 0; m_mem_addr = '0; m_mem_wdata = '0;
            m_d_rdata = '0; m_i_rdata = '0;
            m_i_done = 0; m_d_done = 0; m_err = 0; m_err_sticky = 0;
        end else if (m_resp) begin
            m_resp = 0; m_i_done = 0; m_d_done = 0; m_err = 0;
        end else if (m_busy) begin
            if (mem_ack || m_wait + 1 == TIMEOUT) begin
                m_busy = 0; m_resp = 1; m_mem_req = 0;
                if (m_own_d) m_d_done = 1; else m_i_done = 1;
                if (mem_ack) begin
                    if (m_own_d) m_d_rdata = mem_rdata; else m_i_rdata = mem_rdata[31:0];
                end else begin
                    m_err = 1; m_err_sticky = 1;
                end
            end else begin
                m_wait++;
            end
        end else if (d_req && (!i_req || m_streak < MAX_STARVE)) begin
            m_busy = 1; m_own_d = 1; m_wait = 0;
            m_mem_req = 1; m_mem_we = d_we; m_mem_addr = d_addr; m_mem_wdata = d_wdata;
            m_streak = i_req ? ((m_streak < MAX_STARVE) ? m_streak + 1 : m_streak) : 0;
        end else if (i_req) begin
            m_busy = 1; m_own_d = 0; m_wait = 0;
            m_mem_req = 1; m_mem_we = 0; m_mem_addr = i_addr; m_mem_wdata = '0;
            m_streak = 0;
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, m_mem_req);
            chk("mem_we", mem_we, m_mem_we);
            chk("mem_addr", mem_addr, m_mem_addr);
            chk("mem_wdata", mem_wdata, m_mem_wdata);
            chk("i_done", i_done, m_i_done);
            chk("d_done", d_done, m_d_done);
            chk("i_rdata", i_rdata, m_i_rdata);
            chk("d_rdata", d_rdata, m_d_rdata);
            chk("err", err, m_err);
            chk("err_sticky", err_sticky, m_err_sticky);
            chk("i_stall", i_stall, i_req & ~m_i_done);
            chk("d_stall", d_stall, d_req & ~m_d_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic i_act = 0, i_fin = 0, d_act = 0, d_fin = 0;
    int   ack_pct;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b1;
        chk_en = 1'b1;
        tick();

        // single fetch, ack in third busy cycle
        i_req = 1; i_addr = 64'h40;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 64'h40);
        chk("t1_mem_we", mem_we, 0);
        tick(); tick();
        mem_ack = 1; mem_rdata = 64'h00A00093;
        tick();
        chk("t1_i_done", i_done, 1);
        chk("t1_i_rdata", i_rdata, 32'h00A00093);
        chk("t1_i_stall", i_stall, 0);
        mem_ack = 0;
        tick();
        i_req = 0;
        chk("t1_done_once", i_done, 0);
        tick();

        // simultaneous fetch and store: store first
        i_req = 1; i_addr = 64'h80;
        d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEAD;
        tick();
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 64'hDEAD);
        chk("t2_mem_addr", mem_addr, 64'h100);
        chk("t2_i_stall_busy", i_stall, 1);
        mem_ack = 1; mem_rdata = '0;
        tick();
        chk("t2_d_done", d_done, 1);
        chk("t2_i_stall_resp", i_stall, 1);
        mem_ack = 0;
        tick();
        d_req = 0; d_we = 0;
        chk("t2_i_stall_idle", i_stall, 1);
        tick();
        chk("t2_fetch_addr", mem_addr, 64'h80);
        chk("t2_fetch_we", mem_we, 0);
        chk("t2_fetch_wdata", mem_wdata, 0);
        mem_ack = 1;
        tick();
        chk("t2_i_done", i_done, 1);
        mem_ack = 0;
        tick();
        i_req = 0;
        tick();

        // continuous contention: D,D,D,I repeating
        d_req = 1; d_we = 0; d_addr = 64'h200;
        i_req = 1; i_addr = 64'h300;
        mem_ack = 1; mem_rdata = 64'h123456789ABCDEF0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_grant_addr", mem_addr, (k % 4 == 3) ? 64'h300 : 64'h200);
            tick();
            tick();
        end
        chk("t3_model_streak", m_streak, 0);
        d_req = 0; i_req = 0; mem_ack = 0;
        tick();

        // load that never gets an ack
        d_req = 1; d_we = 0; d_addr = 64'h500;
        tick();
        for (int j = 0; j < 14; j++) begin
            chk("t4_busy_req", mem_req, 1);
            tick();
        end
        chk("t4_busy15_req", mem_req, 1);
        chk("t4_busy15_done", d_done, 0);
        tick();
        chk("t4_err", err, 1);
        chk("t4_d_done", d_done, 1);
        chk("t4_err_sticky", err_sticky, 1);
        chk("t4_d_rdata", d_rdata, 64'h123456789ABCDEF0);
        chk("t4_model_err", m_err, 1);
        tick();
        d_req = 0;
        chk("t4_mem_req_low", mem_req, 0);
        chk("t4_err_clear", err, 0);
        chk("t4_sticky_held", err_sticky, 1);
        tick();

        // reset asserted mid BUSY_D
        d_req = 1; d_we = 1; d_addr = 64'h600; d_wdata = 64'hBEEF;
        tick();
        chk("t5_mem_req_pre", mem_req, 1);
        #1 reset = 0;
        #1;
        chk("t5_mem_req_rst", mem_req, 0);
        chk("t5_sticky_rst", err_sticky, 0);
        d_req = 0; d_we = 0;
        @(posedge clk);
        #2 reset = 1;
        for (int j = 0; j < 3; j++) begin
            chk("t5_no_done", d_done, 0);
            tick();
        end
        d_req = 1; d_we = 1; d_addr = 64'h700; d_wdata = 64'h77;
        mem_ack = 1; mem_rdata = 64'hCAFE;
        tick();
        chk("t5_next_req", mem_req, 1);
        chk("t5_next_addr", mem_addr, 64'h700);
        tick();
        chk("t5_next_done", d_done, 1);
        chk("t5_next_rdata", d_rdata, 64'hCAFE);
        mem_ack = 0;
        tick();
        d_req = 0; d_we = 0;
        tick();

        // spurious ack while idle
        mem_ack = 1; mem_rdata = 64'hFFFF0000FFFF0000;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t6_i_done", i_done, 0);
            chk("t6_d_done", d_done, 0);
            chk("t6_i_rdata", i_rdata, 0);
            chk("t6_d_rdata", d_rdata, 64'hCAFE);
        end
        mem_ack = 0;
        tick();

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ack_pct = (cyc < 1000) ? 60 : (cyc < 2000) ? 25 : (cyc < 2600) ? 4 : 0;
            if (i_act && m_i_done) i_fin = 1;
            else if (i_fin) begin i_fin = 0; i_act = 0; i_req = 0; end
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; i_req = 1; i_addr = {$urandom, $urandom};
            end
            if (d_act && m_d_done) d_fin = 1;
            else if (d_fin) begin d_fin = 0; d_act = 0; d_req = 0; end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_req = 1; d_we = $urandom_range(0, 1) == 1;
                d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            end
            mem_ack = $urandom_range(0, 99) < ack_pct;
            mem_rdata = {$urandom, $urandom};
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 0;
                i_req = 0; d_req = 0; i_act = 0; d_act = 0; i_fin = 0; d_fin = 0;
                @(posedge clk);
                #2 reset = 1;
            end else begin
                tick();
            end
        end
        i_req = 0; d_req = 0; mem_ack = 0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
